// File: rtl/pending_enc_pkg.sv
// Shared sizes, priority-mode selectors and the popcount helper for the
// pending request encoder.
package pending_enc_pkg;

    localparam int N_IN       = 8;
    localparam int IDX_W      = $clog2(N_IN);
    localparam int CNT_W      = IDX_W + 1;

    localparam int PRIO_FIXED = 0;
    localparam int PRIO_RR    = 1;

    function automatic logic [CNT_W-1:0] popcount8(input logic [N_IN-1:0] vec);
        logic [CNT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < N_IN; i++) begin
            cnt = cnt + CNT_W'(vec[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/pending_encoder_8to3_prio_enc8.sv
// Combinational 8-input priority encoder; MSB_FIRST picks the highest set bit,
// otherwise the lowest. idx reads 0 when no bit is set.
module prio_enc8
    import pending_enc_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic [N_IN-1:0]  vec,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    // NOTE: every output gets a default before the search loop so no latch is inferred.
    always_comb begin
        valid = |vec;
        idx   = '0;
        if (MSB_FIRST) begin
            // Ascending scan: the last hit is the highest set bit.
            for (int i = 0; i < N_IN; i++) begin
                if (vec[i]) idx = IDX_W'(i);
            end
        end else begin
            for (int i = N_IN - 1; i >= 0; i--) begin
                if (vec[i]) idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/pending_encoder_8to3.sv
// Sticky pending register for 8 request lines; presents the selected pending
// index over valid/ready and clears that bit when it is accepted.
module pending_encoder_8to3
    import pending_enc_pkg::*;
#(
    parameter int ROUND_ROBIN = PRIO_FIXED
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IN-1:0]  req,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx,
    output logic [N_IN-1:0]  pending,
    output logic [CNT_W-1:0] pend_cnt,
    output logic             overflow
);

    logic            accept;
    logic [N_IN-1:0] clr;
    logic [N_IN-1:0] pending_next;
    logic            overflow_next;

    generate
        if (ROUND_ROBIN == PRIO_RR) begin : g_rr
            logic [IDX_W-1:0] rr_ptr;
            logic [N_IN-1:0]  masked;
            logic             m_valid;
            logic [IDX_W-1:0] m_idx;
            logic [IDX_W-1:0] u_idx;

            // Bits at or above the pointer win; the unmasked search covers the wrap.
            assign masked = pending & ({N_IN{1'b1}} << rr_ptr);

            prio_enc8 #(.MSB_FIRST(1'b0)) u_masked (
                .vec   (masked),
                .valid (m_valid),
                .idx   (m_idx)
            );

            prio_enc8 #(.MSB_FIRST(1'b0)) u_fallback (
                .vec   (pending),
                .valid (out_valid),
                .idx   (u_idx)
            );

            assign out_idx = m_valid ? m_idx : u_idx;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rr_ptr <= '0;
                end else if (accept) begin
                    rr_ptr <= out_idx + IDX_W'(1);
                end
            end
        end else begin : g_fixed
            prio_enc8 #(.MSB_FIRST(1'b1)) u_fixed (
                .vec   (pending),
                .valid (out_valid),
                .idx   (out_idx)
            );
        end
    endgenerate

    assign accept        = out_valid & out_ready;
    assign clr           = accept ? (N_IN'(1) << out_idx) : '0;
    // A request landing on the bit being cleared keeps it set and is not an overflow.
    assign pending_next  = (pending & ~clr) | req;
    assign overflow_next = |(req & pending & ~clr);
    assign pend_cnt      = popcount8(pending);

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending  <= '0;
            overflow <= 1'b0;
        end else begin
            pending  <= pending_next;
            overflow <= overflow_next;
        end
    end

endmodule

// File: tb/tb_pending_encoder_8to3.sv
// Scoreboard bench: one fixed-priority and one round-robin instance share the
// stimulus; a behavioural model predicts each cycle's outputs.
module tb_pending_encoder_8to3;

    typedef struct {
        logic       valid;
        logic [2:0] idx;
        logic [7:0] pend;
        logic [3:0] cnt;
        logic       ovf;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'h00;
    logic       out_ready = 1'b0;

    logic       f_valid, r_valid;
    logic [2:0] f_idx, r_idx;
    logic [7:0] f_pend, r_pend;
    logic [3:0] f_cnt, r_cnt;
    logic       f_ovf, r_ovf;

    int n_checks = 0;
    int n_pass   = 0;

    exp_t q_f[$];
    exp_t q_r[$];

    logic [7:0] m_pend[2];
    int         m_ptr[2];

    always #5 clk = ~clk;

    pending_encoder_8to3 #(.ROUND_ROBIN(0)) dut_fixed (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .out_ready (out_ready),
        .out_valid (f_valid),
        .out_idx   (f_idx),
        .pending   (f_pend),
        .pend_cnt  (f_cnt),
        .overflow  (f_ovf)
    );

    pending_encoder_8to3 #(.ROUND_ROBIN(1)) dut_rr (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .out_ready (out_ready),
        .out_valid (r_valid),
        .out_idx   (r_idx),
        .pending   (r_pend),
        .pend_cnt  (r_cnt),
        .overflow  (r_ovf)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Model: fixed = highest pending index; rr = first pending index scanning
    // upward from the pointer with wrap-around.
    function automatic int pick(input int mode, input logic [7:0] p, input int ptr);
        int i;
        if (mode == 0) begin
            for (int k = 7; k >= 0; k--) if (p[k]) return k;
        end else begin
            for (int k = 0; k < 8; k++) begin
                i = (ptr + k) % 8;
                if (p[i]) return i;
            end
        end
        return 0;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_pend[m] = 8'h00;
            m_ptr[m]  = 0;
        end
        q_f.delete();
        q_r.delete();
    endtask

    task automatic model_step(input int m, input logic [7:0] r, input logic y);
        int         sel;
        bit         acc, cl, ovf;
        logic [7:0] nx;
        exp_t       e;
        sel = pick(m, m_pend[m], m_ptr[m]);
        acc = (m_pend[m] != 8'h00) && y;
        ovf = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cl = acc && (i == sel);
            if (r[i] && m_pend[m][i] && !cl) ovf = 1'b1;
            nx[i] = (m_pend[m][i] && !cl) || r[i];
        end
        m_pend[m] = nx;
        if (acc && m == 1) m_ptr[m] = (sel + 1) % 8;
        e.valid = (nx != 8'h00);
        e.idx   = 3'(pick(m, nx, m_ptr[m]));
        e.pend  = nx;
        e.cnt   = 4'd0;
        for (int i = 0; i < 8; i++) e.cnt = e.cnt + 4'(nx[i]);
        e.ovf   = ovf;
        if (m == 0) q_f.push_back(e);
        else        q_r.push_back(e);
    endtask

    task automatic step(input logic [7:0] r, input logic y);
        @(negedge clk);
        req       = r;
        out_ready = y;
        model_step(0, r, y);
        model_step(1, r, y);
    endtask

    task automatic cmp(input string tag, input exp_t e, input logic v, input logic [2:0] idx,
                       input logic [7:0] p, input logic [3:0] c, input logic o);
        check({tag, "_valid"},    32'(v),   32'(e.valid));
        check({tag, "_idx"},      32'(idx), 32'(e.idx));
        check({tag, "_pending"},  32'(p),   32'(e.pend));
        check({tag, "_pend_cnt"}, 32'(c),   32'(e.cnt));
        check({tag, "_overflow"}, 32'(o),   32'(e.ovf));
    endtask

    // Monitor: compare one predicted state per instance after each active edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                if (q_f.size() > 0) begin
                    e = q_f.pop_front();
                    cmp("fix", e, f_valid, f_idx, f_pend, f_cnt, f_ovf);
                end
                if (q_r.size() > 0) begin
                    e = q_r.pop_front();
                    cmp("rr", e, r_valid, r_idx, r_pend, r_cnt, r_ovf);
                end
            end
        end
    end

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        req       = 8'hFF;
        out_ready = 1'b0;
        model_reset();
        @(negedge clk);
        req = 8'h00;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        req = 8'hFF;
        repeat (2) @(posedge clk);
        #1;
        check("rst_fix_pending", 32'(f_pend), 32'h00);
        check("rst_fix_valid",   32'(f_valid), 32'h0);
        check("rst_rr_pending",  32'(r_pend), 32'h00);
        check("rst_rr_valid",    32'(r_valid), 32'h0);
        @(negedge clk);
        req = 8'h00;
        rst = 1'b0;
        step(8'h00, 1'b0);
        after_edge();
        check("post_rst_valid", 32'(f_valid), 32'h0);

        // Single request, then accept.
        step(8'h20, 1'b0);
        after_edge();
        check("single_idx", 32'(f_idx), 32'd5);
        check("single_cnt", 32'(f_cnt), 32'd1);
        step(8'h00, 1'b1);
        after_edge();
        check("single_cleared", 32'(f_pend), 32'h00);

        // Fixed priority with ready held.
        step(8'h81, 1'b1);
        after_edge();
        check("prio_first_idx", 32'(f_idx), 32'd7);
        step(8'h00, 1'b1);
        after_edge();
        check("prio_second_idx", 32'(f_idx), 32'd0);
        step(8'h00, 1'b1);

        // Backpressure and overflow.
        step(8'h08, 1'b0);
        step(8'h08, 1'b0);
        after_edge();
        check("ovf_pulse", 32'(f_ovf), 32'h1);
        step(8'h00, 1'b0);
        after_edge();
        check("ovf_one_cycle", 32'(f_ovf), 32'h0);
        check("ovf_idx_stable", 32'(f_idx), 32'd3);
        step(8'h00, 1'b1);

        // Simultaneous clear and request on the same bit.
        step(8'h04, 1'b0);
        step(8'h04, 1'b1);
        after_edge();
        check("clr_req_pending", 32'(f_pend), 32'h04);
        check("clr_req_no_ovf",  32'(f_ovf), 32'h0);
        step(8'h00, 1'b1);
        step(8'h00, 1'b1);

        // Round robin sweep from a fresh pointer.
        do_reset();
        step(8'hFF, 1'b1);
        after_edge();
        check("rr_first_idx", 32'(r_idx), 32'd0);
        repeat (8) step(8'h00, 1'b1);
        after_edge();
        check("rr_drained", 32'(r_valid), 32'h0);
        step(8'h03, 1'b1);
        after_edge();
        check("rr_wrap_idx0", 32'(r_idx), 32'd0);
        step(8'h00, 1'b1);
        after_edge();
        check("rr_wrap_idx1", 32'(r_idx), 32'd1);
        step(8'h00, 1'b1);

        // Randomized traffic with bursts of backpressure.
        for (int i = 0; i < 400; i++) begin
            step(8'($urandom & $urandom), (i % 40 < 8) ? 1'b0 : ($urandom_range(0, 3) != 0));
        end

        // Asynchronous reset mid-cycle with state pending.
        step(8'hA5, 1'b0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("async_fix_valid", 32'(f_valid), 32'h0);
        check("async_fix_cnt",   32'(f_cnt), 32'h0);
        check("async_rr_pending", 32'(r_pend), 32'h00);
        model_reset();
        @(negedge clk);
        req = 8'h00;
        rst = 1'b0;
        step(8'h00, 1'b1);
        step(8'h42, 1'b1);
        step(8'h00, 1'b1);
        step(8'h00, 1'b1);

        after_edge();
        check("drain_fix", 32'(q_f.size()), 32'd0);
        check("drain_rr",  32'(q_r.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
